sync_fifo_ctrl: RTL and testbench

SYNC_FIFO_CTRL -- requirements
Module: sync_fifo_ctrl

---
 rtl/sync_fifo_ctrl.sv | 140 ++++++++++++++
 tb/tb_sync_fifo_ctrl.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sync_fifo_ctrl.sv
// -----------------------------------------------------------------------------
// sync_fifo_ctrl
//
// Pointer, occupancy and status control for a single-clock FIFO built around
// an external RAM with a one-cycle read latency. The RAM itself is not part of
// this block; only its write/read strobes and addresses are produced here.
//
// Build option:
//   SYNC_FIFO_ALMOST_FLAGS_EN  when defined, adds the registered almost_full and
//                              almost_empty ports and their logic.
//
// Parameters:
//   DEPTH       number of RAM entries (2 .. 2**ADDR_WIDTH, need not be a power of 2)
//   ADDR_WIDTH  RAM address width
//   AF_LEVEL    almost_full asserts when count >= AF_LEVEL
//   AE_LEVEL    almost_empty asserts when count <= AE_LEVEL
//
// Ports:
//   clk           single clock, rising edge
//   rst_n         synchronous active-low reset
//   wr_en, rd_en  push / pop requests
//   ram_w_enable  RAM write strobe (accepted push, combinational)
//   ram_w_addr    RAM write address (write pointer register)
//   ram_r_enable  RAM read strobe (accepted pop, combinational)
//   ram_r_addr    RAM read address (read pointer register)
//   rd_valid      RAM read data holds the popped word this cycle
//   full, empty   registered status flags
//   count         current occupancy
//   overflow      one-cycle pulse after a push request while full
//   underflow     one-cycle pulse after a pop request while empty
//   almost_full, almost_empty   (SYNC_FIFO_ALMOST_FLAGS_EN only)
// -----------------------------------------------------------------------------
module sync_fifo_ctrl #(
    parameter int DEPTH      = 512,
    parameter int ADDR_WIDTH = 9,
    parameter int AF_LEVEL   = 508,
    parameter int AE_LEVEL   = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en,
    input  logic                  rd_en,
    output logic                  ram_w_enable,
    output logic [ADDR_WIDTH-1:0] ram_w_addr,
    output logic                  ram_r_enable,
    output logic [ADDR_WIDTH-1:0] ram_r_addr,
    output logic                  rd_valid,
    output logic                  full,
    output logic                  empty,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  overflow,
    output logic                  underflow
`ifdef SYNC_FIFO_ALMOST_FLAGS_EN
    ,
    output logic                  almost_full,
    output logic                  almost_empty
`endif
);

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);
    localparam logic [ADDR_WIDTH:0]   DEPTH_CNT = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0]   CNT_ONE   = (ADDR_WIDTH + 1)'(1);
    localparam logic [ADDR_WIDTH-1:0] PTR_ONE   = ADDR_WIDTH'(1);

    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic [ADDR_WIDTH-1:0] wr_ptr_nxt;
    logic [ADDR_WIDTH-1:0] rd_ptr_nxt;
    logic [ADDR_WIDTH:0]   count_nxt;
    logic                  wr_accept;
    logic                  rd_accept;

    // Accept decisions use the registered flags only, so a simultaneous pop
    // never frees a slot for a push in the same cycle (and vice versa). The
    // rst_n term keeps the RAM strobes quiet during reset.
    assign wr_accept = rst_n & wr_en & ~full;
    assign rd_accept = rst_n & rd_en & ~empty;

    assign ram_w_enable = wr_accept;
    assign ram_r_enable = rd_accept;
    assign ram_w_addr   = wr_ptr;
    assign ram_r_addr   = rd_ptr;

    // Explicit wrap at DEPTH-1 so non-power-of-two depths work.
    assign wr_ptr_nxt = (wr_ptr == LAST_ADDR) ? '0 : wr_ptr + PTR_ONE;
    assign rd_ptr_nxt = (rd_ptr == LAST_ADDR) ? '0 : rd_ptr + PTR_ONE;

    always_comb begin
        count_nxt = count;
        case ({wr_accept, rd_accept})
            2'b10:   count_nxt = count + CNT_ONE;
            2'b01:   count_nxt = count - CNT_ONE;
            default: count_nxt = count;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            full      <= 1'b0;
            empty     <= 1'b1;
            rd_valid  <= 1'b0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr_accept) begin
                wr_ptr <= wr_ptr_nxt;
            end
            if (rd_accept) begin
                rd_ptr <= rd_ptr_nxt;
            end
            count     <= count_nxt;
            // Flags come from the next count so they change on the same edge.
            full      <= (count_nxt == DEPTH_CNT);
            empty     <= (count_nxt == '0);
            // RAM returns data one cycle after the read strobe.
            rd_valid  <= rd_accept;
            overflow  <= wr_en & full;
            underflow <= rd_en & empty;
        end
    end

`ifdef SYNC_FIFO_ALMOST_FLAGS_EN
    localparam logic [ADDR_WIDTH:0] AF_CNT = (ADDR_WIDTH + 1)'(AF_LEVEL);
    localparam logic [ADDR_WIDTH:0] AE_CNT = (ADDR_WIDTH + 1)'(AE_LEVEL);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            almost_full  <= 1'b0;
            almost_empty <= 1'b1;
        end else begin
            almost_full  <= (count_nxt >= AF_CNT);
            almost_empty <= (count_nxt <= AE_CNT);
        end
    end
`endif

endmodule

// File: tb/tb_sync_fifo_ctrl.sv
// -----------------------------------------------------------------------------
// tb_sync_fifo_ctrl
//
// Self-checking bench for sync_fifo_ctrl at DEPTH=8, ADDR_WIDTH=3, AF_LEVEL=6,
// AE_LEVEL=1. A vector table covers fill / overflow / drain / underflow, then
// hand-written sequences cover the multi-cycle corners, then random traffic.
// Every cycle is also compared against a reference model that tracks only the
// total number of accepted pushes and pops since reset: occupancy is their
// difference and the RAM addresses are each total modulo DEPTH.
// -----------------------------------------------------------------------------
module tb_sync_fifo_ctrl;

    localparam int DEPTH = 8;
    localparam int AW    = 3;
    localparam int AF    = 6;
    localparam int AE    = 1;

    logic          clk;
    logic          rst_n;
    logic          wr_en;
    logic          rd_en;
    logic          ram_w_enable;
    logic [AW-1:0] ram_w_addr;
    logic          ram_r_enable;
    logic [AW-1:0] ram_r_addr;
    logic          rd_valid;
    logic          full;
    logic          empty;
    logic [AW:0]   count;
    logic          overflow;
    logic          underflow;
`ifdef SYNC_FIFO_ALMOST_FLAGS_EN
    logic          almost_full;
    logic          almost_empty;
`endif

    sync_fifo_ctrl #(
        .DEPTH      (DEPTH),
        .ADDR_WIDTH (AW),
        .AF_LEVEL   (AF),
        .AE_LEVEL   (AE)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .wr_en        (wr_en),
        .rd_en        (rd_en),
        .ram_w_enable (ram_w_enable),
        .ram_w_addr   (ram_w_addr),
        .ram_r_enable (ram_r_enable),
        .ram_r_addr   (ram_r_addr),
        .rd_valid     (rd_valid),
        .full         (full),
        .empty        (empty),
        .count        (count),
        .overflow     (overflow),
        .underflow    (underflow)
`ifdef SYNC_FIFO_ALMOST_FLAGS_EN
        ,
        .almost_full  (almost_full),
        .almost_empty (almost_empty)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state.
    int wr_total = 0;
    int rd_total = 0;
    bit m_rv     = 1'b0;
    bit m_ov     = 1'b0;
    bit m_un     = 1'b0;

    typedef struct {
        bit rst_n;
        bit wr;
        bit rd;
        bit wen;
        int waddr;
        bit ren;
        int raddr;
        int cnt;
        bit full;
        bit empty;
        bit rv;
        bit ov;
        bit un;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: actual=%0d required=%0d at %0t", name, act, exp, $time);
    endtask

    task automatic add_vec(input bit r_n, input bit w, input bit r,
                           input bit wen, input int waddr, input bit ren, input int raddr,
                           input int cnt, input bit f, input bit e,
                           input bit rv, input bit ov, input bit un);
        vec_t v;
        v.rst_n = r_n; v.wr = w; v.rd = r;
        v.wen = wen; v.waddr = waddr; v.ren = ren; v.raddr = raddr;
        v.cnt = cnt; v.full = f; v.empty = e; v.rv = rv; v.ov = ov; v.un = un;
        vecs.push_back(v);
    endtask

    // One clock cycle: drive at negedge, check combinational outputs, take the
    // edge, advance the model, check registered outputs. When has_vec is set,
    // the table record's fixed expectations are checked as well.
    task automatic cycle(input bit r_n, input bit w, input bit r,
                         input bit has_vec, input vec_t v);
        int  occ;
        bit  e_wen;
        bit  e_ren;
        @(negedge clk);
        rst_n = r_n;
        wr_en = w;
        rd_en = r;
        #1;
        occ   = wr_total - rd_total;
        e_wen = r_n && w && (occ != DEPTH);
        e_ren = r_n && r && (occ != 0);
        chk("ram_w_enable", int'(ram_w_enable), int'(e_wen));
        chk("ram_r_enable", int'(ram_r_enable), int'(e_ren));
        chk("ram_w_addr", int'(ram_w_addr), wr_total % DEPTH);
        chk("ram_r_addr", int'(ram_r_addr), rd_total % DEPTH);
        if (has_vec) begin
            chk("vec ram_w_enable", int'(ram_w_enable), int'(v.wen));
            chk("vec ram_w_addr", int'(ram_w_addr), v.waddr);
            chk("vec ram_r_enable", int'(ram_r_enable), int'(v.ren));
            chk("vec ram_r_addr", int'(ram_r_addr), v.raddr);
        end
        @(posedge clk);
        if (!r_n) begin
            wr_total = 0;
            rd_total = 0;
            m_rv = 1'b0;
            m_ov = 1'b0;
            m_un = 1'b0;
        end else begin
            m_ov = w && (occ == DEPTH);
            m_un = r && (occ == 0);
            m_rv = e_ren;
            if (e_wen) wr_total++;
            if (e_ren) rd_total++;
        end
        occ = wr_total - rd_total;
        #1;
        chk("count", int'(count), occ);
        chk("full", int'(full), int'(occ == DEPTH));
        chk("empty", int'(empty), int'(occ == 0));
        chk("rd_valid", int'(rd_valid), int'(m_rv));
        chk("overflow", int'(overflow), int'(m_ov));
        chk("underflow", int'(underflow), int'(m_un));
`ifdef SYNC_FIFO_ALMOST_FLAGS_EN
        chk("almost_full", int'(almost_full), int'(occ >= AF));
        chk("almost_empty", int'(almost_empty), int'(occ <= AE));
`endif
        if (has_vec) begin
            chk("vec count", int'(count), v.cnt);
            chk("vec full", int'(full), int'(v.full));
            chk("vec empty", int'(empty), int'(v.empty));
            chk("vec rd_valid", int'(rd_valid), int'(v.rv));
            chk("vec overflow", int'(overflow), int'(v.ov));
            chk("vec underflow", int'(underflow), int'(v.un));
`ifdef SYNC_FIFO_ALMOST_FLAGS_EN
            chk("vec almost_full", int'(almost_full), int'(v.cnt >= AF));
            chk("vec almost_empty", int'(almost_empty), int'(v.cnt <= AE));
`endif
        end
    endtask

    task automatic step(input bit r_n, input bit w, input bit r);
        vec_t dummy;
        dummy = '{default: 0};
        cycle(r_n, w, r, 1'b0, dummy);
    endtask

    initial begin
        rst_n = 1'b0;
        wr_en = 1'b0;
        rd_en = 1'b0;
        repeat (2) @(posedge clk);

        // rst wr rd | wen waddr ren raddr | cnt full empty rv ov un
        // Reset with both requests high: strobes must stay low.
        add_vec(0, 1, 1,  0, 0, 0, 0,  0, 0, 1, 0, 0, 0);
        // Eight writes fill the FIFO.
        for (int i = 0; i < DEPTH; i++)
            add_vec(1, 1, 0,  1, i, 0, 0,  i + 1, (i == DEPTH - 1), 0, 0, 0, 0);
        // Ninth write while full: rejected, overflow pulse, pointer already wrapped.
        add_vec(1, 1, 0,  0, 0, 0, 0,  DEPTH, 1, 0, 0, 1, 0);
        add_vec(1, 0, 0,  0, 0, 0, 0,  DEPTH, 1, 0, 0, 0, 0);
        // Eight reads drain it, rd_valid the cycle after each.
        for (int i = 0; i < DEPTH; i++)
            add_vec(1, 0, 1,  0, 0, 1, i,  DEPTH - 1 - i, 0, (i == DEPTH - 1), 1, 0, 0);
        // Read while empty: rejected, underflow pulse, no rd_valid.
        add_vec(1, 0, 1,  0, 0, 0, 0,  0, 0, 1, 0, 0, 1);
        add_vec(1, 0, 0,  0, 0, 0, 0,  0, 0, 1, 0, 0, 0);

        foreach (vecs[k]) cycle(vecs[k].rst_n, vecs[k].wr, vecs[k].rd, 1'b1, vecs[k]);

        // Five writes then twenty simultaneous push/pop cycles: occupancy
        // holds at 5 while both pointers wrap.
        step(0, 0, 0);
        repeat (5) step(1, 1, 0);
        for (int i = 0; i < 20; i++) begin
            step(1, 1, 1);
            chk("steady count", int'(count), 5);
        end

        // Reset with a read in flight: count, empty and rd_valid clear.
        step(1, 0, 1);
        step(0, 0, 0);
        chk("reset count", int'(count), 0);
        chk("reset empty", int'(empty), 1);
        chk("reset rd_valid", int'(rd_valid), 0);

        // Empty with both requested: write wins, no rd_valid afterwards.
        step(1, 1, 1);
        chk("empty both count", int'(count), 1);
        chk("empty both rd_valid", int'(rd_valid), 0);

        // Full with both requested: read wins.
        repeat (DEPTH - 1) step(1, 1, 0);
        step(1, 1, 1);
        chk("full both count", int'(count), DEPTH - 1);
        chk("full both rd_valid", int'(rd_valid), 1);

        // Random traffic with phase-varying push/pop bias and rare resets.
        for (int p = 0; p < 6; p++) begin
            int wp;
            int rp;
            wp = $urandom_range(20, 80);
            rp = $urandom_range(20, 80);
            for (int i = 0; i < 300; i++) begin
                bit rr;
                rr = ($urandom_range(0, 99) == 0);
                step(!rr, ($urandom_range(0, 99) < wp), ($urandom_range(0, 99) < rp));
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
